store_alignment: RTL and testbench



---
 rtl/store_alignment_pkg.sv | 38 +++
 rtl/store_alignment_if.sv | 29 ++
 rtl/store_alignment_lane_shifter.sv | 31 +++
 rtl/store_alignment.sv | 91 +++++++++
 tb/tb_store_alignment.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_alignment_pkg.sv
// Shared types and store-op encodings for the store alignment path.
// Store-op encodings mirror the core's LOAD_OP set; 0 is reserved as "no store".
package store_alignment_pkg;

    localparam int NUM_LANES      = 4;
    localparam int LANE_W         = 8;
    localparam int VEC_W          = NUM_LANES * LANE_W;
    localparam int STORE_OP_WIDTH = 2;

    localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SB = 2'd1;
    localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SH = 2'd2;
    localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SW = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BEAT0,
        ST_BEAT1,
        ST_FAULT,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic [VEC_W-1:0]     addr;
        logic [VEC_W-1:0]     data;
        logic [NUM_LANES-1:0] mask;
    } beat_t;

    // Unshifted byte-enable footprint of an op; all-zero marks an illegal op.
    function automatic logic [NUM_LANES-1:0] op_bytes_mask(input logic [STORE_OP_WIDTH-1:0] op);
        case (op)
            STORE_OP_SB: op_bytes_mask = 4'b0001;
            STORE_OP_SH: op_bytes_mask = 4'b0011;
            STORE_OP_SW: op_bytes_mask = 4'b1111;
            default:     op_bytes_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/store_alignment_if.sv
// Request and memory-write handshake bundle for store_alignment.
interface store_alignment_if;
    import store_alignment_pkg::*;

    logic                      req_valid;
    logic                      req_ready;
    logic [VEC_W-1:0]          req_addr;
    logic [STORE_OP_WIDTH-1:0] STOREop;
    logic [VEC_W-1:0]          req_data;
    logic                      mem_valid;
    logic                      mem_ready;
    logic [VEC_W-1:0]          mem_addr;
    logic [VEC_W-1:0]          mem_wdata;
    logic [NUM_LANES-1:0]      mem_wmask;
    logic                      done;
    logic                      misaligned;

    // master: control unit + memory side; slave: the alignment unit itself
    modport master (
        output req_valid, req_addr, STOREop, req_data, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wmask, done, misaligned
    );

    modport slave (
        input  req_valid, req_addr, STOREop, req_data, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wmask, done, misaligned
    );

endinterface

// File: rtl/store_alignment_lane_shifter.sv
// Combinational lane shifter: places store bytes into a two-word window
// starting at the byte offset, with matching byte enables.
module store_lane_shifter
    import store_alignment_pkg::*;
(
    input  logic [1:0]                offset,
    input  logic [STORE_OP_WIDTH-1:0] op,
    input  logic [VEC_W-1:0]          data,
    output logic [2*VEC_W-1:0]        wide,
    output logic [2*NUM_LANES-1:0]    mask,
    output logic                      misaligned,
    output logic                      op_valid
);

    logic [NUM_LANES-1:0] bmask;
    logic [VEC_W-1:0]     data_m;

    assign bmask    = op_bytes_mask(op);
    assign op_valid = |bmask;

    // Zero the unused upper bytes of rs2 so they never reach the bus.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign data_m[g*LANE_W +: LANE_W] = bmask[g] ? data[g*LANE_W +: LANE_W] : '0;
    end

    assign wide       = {{VEC_W{1'b0}}, data_m} << {offset, 3'b000};
    assign mask       = {{NUM_LANES{1'b0}}, bmask} << offset;
    assign misaligned = ((op == STORE_OP_SH) && offset[0]) ||
                        ((op == STORE_OP_SW) && (offset != 2'b00));

endmodule

// File: rtl/store_alignment.sv
// Store alignment unit: accepts one SB/SH/SW, issues one or two aligned
// write beats (or a fault), then pulses done.
module store_alignment
    import store_alignment_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    store_alignment_if.slave  bus
);

    state_e                 state_q, state_d;
    beat_t                  beat_q;      // beat currently presented on the bus
    beat_t                  beat1_q;     // pending upper beat of a split store
    logic                   need_b1_q;
    logic                   mis_q;

    logic [2*VEC_W-1:0]     sh_wide;
    logic [2*NUM_LANES-1:0] sh_mask;
    logic                   sh_mis;
    logic                   sh_op_ok;
    logic                   accept;
    logic                   fault;
    logic [VEC_W-1:0]       word_addr;
    beat_t                  acc_beat0;
    beat_t                  acc_beat1;

    store_lane_shifter u_shifter (
        .offset     (bus.req_addr[1:0]),
        .op         (bus.STOREop),
        .data       (bus.req_data),
        .wide       (sh_wide),
        .mask       (sh_mask),
        .misaligned (sh_mis),
        .op_valid   (sh_op_ok)
    );

    assign accept    = (state_q == ST_IDLE) && bus.req_valid;
    assign fault     = !sh_op_ok || (sh_mis && !ALLOW_MISALIGNED);
    assign word_addr = {bus.req_addr[VEC_W-1:2], 2'b00};
    // Upper beat address wraps naturally at 2^32.
    assign acc_beat0 = '{addr: word_addr,          data: sh_wide[VEC_W-1:0],       mask: sh_mask[NUM_LANES-1:0]};
    assign acc_beat1 = '{addr: word_addr + 32'd4,  data: sh_wide[2*VEC_W-1:VEC_W], mask: sh_mask[2*NUM_LANES-1:NUM_LANES]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.req_valid) state_d = fault ? ST_FAULT : ST_BEAT0;
            ST_BEAT0: if (bus.mem_ready) state_d = need_b1_q ? ST_BEAT1 : ST_RESP;
            ST_BEAT1: if (bus.mem_ready) state_d = ST_RESP;
            ST_FAULT: state_d = ST_IDLE;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            beat1_q   <= '0;
            need_b1_q <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mis_q <= sh_mis;
                if (!fault) begin
                    beat_q    <= acc_beat0;
                    beat1_q   <= acc_beat1;
                    need_b1_q <= |sh_mask[2*NUM_LANES-1:NUM_LANES];
                end
            end
            // Bus outputs return to zero once the last beat is taken.
            if (state_q == ST_BEAT0 && bus.mem_ready)
                beat_q <= need_b1_q ? beat1_q : '0;
            if (state_q == ST_BEAT1 && bus.mem_ready)
                beat_q <= '0;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.mem_valid  = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);
    assign bus.done       = (state_q == ST_FAULT) || (state_q == ST_RESP);
    assign bus.misaligned = bus.done && mis_q;
    assign bus.mem_addr   = beat_q.addr;
    assign bus.mem_wdata  = beat_q.data;
    assign bus.mem_wmask  = beat_q.mask;

endmodule

// File: tb/tb_store_alignment.sv
// Scoreboard bench for store_alignment: a split-capable and a fault-only instance.
module tb_store_alignment;
    import store_alignment_pkg::*;

    typedef struct {
        bit          is_done;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        bit          mis;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    ev_t q0[$];
    ev_t q1[$];

    logic        rq_v[2]  = '{1'b0, 1'b0};
    logic [31:0] rq_a[2]  = '{32'h0, 32'h0};
    logic [1:0]  rq_op[2] = '{2'h0, 2'h0};
    logic [31:0] rq_d[2]  = '{32'h0, 32'h0};
    logic        m_rdy[2] = '{1'b1, 1'b1};
    int          rdy_mode[2]  = '{0, 0};   // 0: tied 1, 1: random, 2: forced
    logic        rdy_force[2] = '{1'b1, 1'b1};

    logic        r_rdy[2], m_v[2], dn[2], mis[2];
    logic [31:0] m_a[2], m_wd[2];
    logic [3:0]  m_wm[2];

    store_alignment_if ifa ();
    store_alignment_if ifb ();

    assign ifa.req_valid = rq_v[0];  assign ifb.req_valid = rq_v[1];
    assign ifa.req_addr  = rq_a[0];  assign ifb.req_addr  = rq_a[1];
    assign ifa.STOREop   = rq_op[0]; assign ifb.STOREop   = rq_op[1];
    assign ifa.req_data  = rq_d[0];  assign ifb.req_data  = rq_d[1];
    assign ifa.mem_ready = m_rdy[0]; assign ifb.mem_ready = m_rdy[1];
    assign r_rdy[0] = ifa.req_ready;  assign r_rdy[1] = ifb.req_ready;
    assign m_v[0]   = ifa.mem_valid;  assign m_v[1]   = ifb.mem_valid;
    assign m_a[0]   = ifa.mem_addr;   assign m_a[1]   = ifb.mem_addr;
    assign m_wd[0]  = ifa.mem_wdata;  assign m_wd[1]  = ifb.mem_wdata;
    assign m_wm[0]  = ifa.mem_wmask;  assign m_wm[1]  = ifb.mem_wmask;
    assign dn[0]    = ifa.done;       assign dn[1]    = ifb.done;
    assign mis[0]   = ifa.misaligned; assign mis[1]   = ifb.misaligned;

    store_alignment #(.ALLOW_MISALIGNED(1'b1)) u_dut_split (.clk(clk), .rst(rst), .bus(ifa.slave));
    store_alignment #(.ALLOW_MISALIGNED(1'b0)) u_dut_fault (.clk(clk), .rst(rst), .bus(ifb.slave));

    task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h", nm, d, act, exp);
        end
    endtask

    task automatic push(input int d, input ev_t e);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Reference: walk the store byte by byte and group bytes by word address.
    task automatic model(input int d, input logic [31:0] a, input logic [1:0] op, input logic [31:0] dat);
        int          n;
        bit          misal, open;
        logic [31:0] ba, w;
        ev_t         e;
        n = (op == STORE_OP_SB) ? 1 : (op == STORE_OP_SH) ? 2 : (op == STORE_OP_SW) ? 4 : 0;
        e.is_done = 1; e.addr = 0; e.data = 0; e.mask = 0; e.mis = 0;
        if (n == 0) begin push(d, e); return; end
        misal = (a % n) != 0;
        if (misal && d == 1) begin e.mis = 1; push(d, e); return; end
        open = 0;
        for (int i = 0; i < n; i++) begin
            ba = a + i;
            w  = {ba[31:2], 2'b00};
            if (open && w != e.addr) begin push(d, e); open = 0; end
            if (!open) begin e.is_done = 0; e.addr = w; e.data = 0; e.mask = 0; e.mis = 0; open = 1; end
            e.data[8*ba[1:0] +: 8] = dat[8*i +: 8];
            e.mask[ba[1:0]] = 1'b1;
        end
        push(d, e);
        e.is_done = 1; e.addr = 0; e.data = 0; e.mask = 0; e.mis = misal;
        push(d, e);
    endtask

    task automatic mon(input int d);
        ev_t e;
        bit  have;
        bit  beat;
        beat = m_v[d] && m_rdy[d];
        if (m_v[d]) check("wmask_nonzero", d, 32'(m_wm[d] != 0), 32'd1);
        if (beat && dn[d]) check("valid_with_done", d, 32'd1, 32'd0);
        if (beat || dn[d]) begin
            have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (!have) begin
                check("unexpected_event", d, {31'd0, dn[d]}, 32'hFFFF_FFFF);
                return;
            end
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            if (beat) begin
                check("beat_kind", d, 32'(e.is_done), 32'd0);
                check("beat_addr", d, m_a[d],  e.addr);
                check("beat_data", d, m_wd[d], e.data);
                check("beat_mask", d, 32'(m_wm[d]), 32'(e.mask));
            end else begin
                check("done_kind", d, 32'(e.is_done), 32'd1);
                check("done_misaligned", d, 32'(mis[d]), 32'(e.mis));
            end
        end
    endtask

    always @(negedge clk) if (!rst) for (int d = 0; d < 2; d++) mon(d);

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++)
            case (rdy_mode[d])
                0:       m_rdy[d] = 1'b1;
                1:       m_rdy[d] = ($urandom_range(0, 3) != 0);
                default: m_rdy[d] = rdy_force[d];
            endcase
    end

    // Returns one time unit after the accepting edge; inputs are scrambled afterwards.
    task automatic issue(input int d, input logic [31:0] a, input logic [1:0] op, input logic [31:0] dat);
        int w = 0;
        while (!r_rdy[d] && w < 100) begin @(posedge clk); #1; w++; end
        if (!r_rdy[d]) begin check("req_ready_timeout", d, 32'd0, 32'd1); return; end
        model(d, a, op, dat);
        rq_v[d] = 1'b1; rq_a[d] = a; rq_op[d] = op; rq_d[d] = dat;
        @(posedge clk); #1;
        rq_v[d] = 1'b0; rq_a[d] = $urandom; rq_op[d] = 2'($urandom); rq_d[d] = $urandom;
    endtask

    task automatic check_beat(input int d, input string nm, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
        check({nm, "_valid"}, d, 32'(m_v[d]), 32'd1);
        check({nm, "_addr"},  d, m_a[d], a);
        check({nm, "_wdata"}, d, m_wd[d], wd);
        check({nm, "_wmask"}, d, 32'(m_wm[d]), 32'(wm));
    endtask

    // Counts negedges until done; exp_n is the expected count from the call.
    task automatic wait_done(input int d, input int exp_n, input bit exp_mis, input string nm);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 40) begin @(negedge clk); n++; if (dn[d]) seen = 1; end
        check({nm, "_done_latency"}, d, 32'(n), 32'(exp_n));
        check({nm, "_misaligned"}, d, 32'(mis[d]), 32'(exp_mis));
    endtask

    task automatic drain();
        int w = 0;
        while ((q0.size() != 0 || q1.size() != 0) && w < 2000) begin @(negedge clk); w++; end
        check("drain_q0", 0, 32'(q0.size()), 32'd0);
        check("drain_q1", 1, 32'(q1.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  op;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_req_ready",  d, 32'(r_rdy[d]), 32'd1);
            check("rst_mem_valid",  d, 32'(m_v[d]), 32'd0);
            check("rst_mem_addr",   d, m_a[d], 32'd0);
            check("rst_mem_wdata",  d, m_wd[d], 32'd0);
            check("rst_mem_wmask",  d, 32'(m_wm[d]), 32'd0);
            check("rst_done",       d, 32'(dn[d]), 32'd0);
            check("rst_misaligned", d, 32'(mis[d]), 32'd0);
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);

        // SB at the top byte lane
        issue(0, 32'h0000_1003, STORE_OP_SB, 32'h0000_00AB);
        @(negedge clk); check_beat(0, "sb", 32'h1000, 32'hAB00_0000, 4'b1000);
        wait_done(0, 1, 1'b0, "sb");
        @(negedge clk);
        check("sb_done_pulse", 0, 32'(dn[0]), 32'd0);
        check("sb_ready_again", 0, 32'(r_rdy[0]), 32'd1);

        // SH misaligned but within one word
        issue(0, 32'h0000_1001, STORE_OP_SH, 32'h0000_1234);
        @(negedge clk); check_beat(0, "sh", 32'h1000, 32'h0012_3400, 4'b0110);
        wait_done(0, 1, 1'b1, "sh");

        // SW split across words, then across the top of the address space
        issue(0, 32'h0000_1003, STORE_OP_SW, 32'hDEAD_BEEF);
        @(negedge clk); check_beat(0, "sw_b0", 32'h1000, 32'hEF00_0000, 4'b1000);
        @(negedge clk); check_beat(0, "sw_b1", 32'h1004, 32'h00DE_ADBE, 4'b0111);
        wait_done(0, 1, 1'b1, "sw_split");
        issue(0, 32'hFFFF_FFFE, STORE_OP_SW, 32'hDEAD_BEEF);
        @(negedge clk); check_beat(0, "wrap_b0", 32'hFFFF_FFFC, 32'hBEEF_0000, 4'b1100);
        @(negedge clk); check_beat(0, "wrap_b1", 32'h0000_0000, 32'h0000_DEAD, 4'b0011);
        wait_done(0, 1, 1'b1, "wrap");

        // Illegal op faults without a beat
        issue(0, 32'h0000_1000, 2'b00, 32'h1111_1111);
        @(negedge clk);
        check("badop_valid", 0, 32'(m_v[0]), 32'd0);
        check("badop_done",  0, 32'(dn[0]), 32'd1);
        check("badop_mis",   0, 32'(mis[0]), 32'd0);

        // Fault-only instance
        issue(1, 32'h0000_1003, STORE_OP_SW, 32'hDEAD_BEEF);
        @(negedge clk);
        check("fault_valid", 1, 32'(m_v[1]), 32'd0);
        check("fault_done",  1, 32'(dn[1]), 32'd1);
        check("fault_mis",   1, 32'(mis[1]), 32'd1);
        @(negedge clk);
        check("fault_done_pulse", 1, 32'(dn[1]), 32'd0);
        check("fault_no_valid",   1, 32'(m_v[1]), 32'd0);
        issue(1, 32'h0000_2004, STORE_OP_SW, 32'h0BAD_F00D);
        wait_done(1, 2, 1'b0, "aligned_nosplit");

        // Backpressure: hold mem_ready low for five cycles
        rdy_force[0] = 1'b0; rdy_mode[0] = 2;
        issue(0, 32'h0000_2000, STORE_OP_SW, 32'hCAFE_F00D);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_beat(0, "bp", 32'h2000, 32'hCAFE_F00D, 4'b1111);
            check("bp_req_ready", 0, 32'(r_rdy[0]), 32'd0);
            check("bp_done", 0, 32'(dn[0]), 32'd0);
        end
        rdy_force[0] = 1'b1;
        @(negedge clk); check_beat(0, "bp_release", 32'h2000, 32'hCAFE_F00D, 4'b1111);
        wait_done(0, 1, 1'b0, "bp");

        // Reset while the upper beat of a split store is pending
        issue(0, 32'h0000_3002, STORE_OP_SW, 32'h0102_0304);
        rdy_force[0] = 1'b0;
        @(negedge clk);
        @(negedge clk); check_beat(0, "rst_b1", 32'h3004, 32'h0000_0102, 4'b0011);
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; q0.delete();
        @(negedge clk);
        check("mid_rst_valid", 0, 32'(m_v[0]), 32'd0);
        check("mid_rst_ready", 0, 32'(r_rdy[0]), 32'd1);
        check("mid_rst_done",  0, 32'(dn[0]), 32'd0);
        rdy_mode[0] = 0;
        repeat (3) @(negedge clk);
        issue(0, 32'h0000_4002, STORE_OP_SB, 32'hFFFF_FF5A);
        @(negedge clk); check_beat(0, "post_rst", 32'h4000, 32'h005A_0000, 4'b0100);
        wait_done(0, 1, 1'b0, "post_rst");

        // Randomised traffic against the scoreboard
        rdy_mode[0] = 1;
        for (int i = 0; i < 200; i++) begin
            a  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : $urandom;
            op = ($urandom_range(0, 15) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            issue(0, a, op, $urandom);
        end
        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 15) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            issue(1, $urandom, op, $urandom);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
